// File: rtl/mul_div_seq_pkg.sv
// ----------------------------------------------------------------------------
// mul_div_seq_pkg
//   Shared constants for the multiply/divide sequencer and its neighbours:
//   - 4-bit ALU opcodes understood by the external ripple ALU
//   - MULTU/DIVU operation encodings on the sequencer's op input
//   - sequencer FSM state encoding
// ----------------------------------------------------------------------------
package mul_div_seq_pkg;

  // ALU opcodes. Bit 2 doubles as B-invert / carry-in, which is what turns
  // ADD into SUB.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Operation select on the op input.
  localparam logic MD_MULTU = 1'b0;
  localparam logic MD_DIVU  = 1'b1;

  // Sequencer states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage : mul_div_seq_pkg

// File: rtl/mul_div_seq.sv
// ----------------------------------------------------------------------------
// mul_div_seq
//   Multi-cycle unsigned MULTU / DIVU sequencer producing HI/LO. It owns no
//   adder: every iteration it drives operands and an opcode to an external
//   combinational ALU and consumes that ALU's result in the same cycle.
//   Shift-add multiply and restoring divide each take WIDTH iterations.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start, op           request (sampled in IDLE only); 0 = MULTU, 1 = DIVU
//   src_a, src_b        multiplicand/dividend, multiplier/divisor
//   alu_a, alu_b,
//   alu_opcode          operands and opcode to the external ALU
//   alu_result          ALU result (combinational from alu_a/alu_b/alu_opcode)
//   alu_zero,
//   alu_overflow        ALU flags, not needed for unsigned operations
//   busy                high while iterating
//   done                one-cycle pulse when hi/lo/div_by_zero are valid
//   div_by_zero         DIVU issued with src_b = 0
//   hi, lo              product high/low half, or remainder/quotient
// ----------------------------------------------------------------------------
module mul_div_seq
  import mul_div_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  // The ALU exposes no carry-out; rebuild it from the MSBs of the operands
  // as seen by the adder (B already inverted for SUB) and of the sum.
  function automatic logic carry_msb(input logic a_msb, input logic b_msb,
                                     input logic r_msb);
    return (a_msb & b_msb) | ((a_msb | b_msb) & ~r_msb);
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             op_q, op_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] b_eff;
  logic             carry;

  // Flags carry nothing for unsigned shift-add / restoring divide.
  logic unused_flags;
  assign unused_flags = &{1'b0, alu_zero, alu_overflow};

  // ALU drive: only RUN uses the ALU; elsewhere it idles on 0 + 0.
  // NOTE: every signal assigned in always_comb gets a default at the top of
  // the block so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = ALU_ADD;
    if (state_q == ST_RUN) begin
      alu_b = m_q;
      if (op_q == MD_DIVU) begin
        // Shift the next dividend bit into the partial remainder and trial-
        // subtract the divisor.
        alu_a      = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        alu_opcode = ALU_SUB;
      end else begin
        alu_a = hi_q;
      end
    end
  end

  assign b_eff = (alu_opcode == ALU_SUB) ? ~alu_b : alu_b;
  assign carry = carry_msb(alu_a[WIDTH-1], b_eff[WIDTH-1], alu_result[WIDTH-1]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = op;
          cnt_d = '0;
          dbz_d = 1'b0;
          hi_d  = '0;
          if (op == MD_DIVU) begin
            m_d  = src_b;
            lo_d = src_a;
            if (src_b == '0) begin
              // Skip iterating: remainder = dividend, quotient = all ones.
              hi_d    = src_a;
              lo_d    = '1;
              dbz_d   = 1'b1;
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            m_d     = src_a;
            lo_d    = src_b;
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == MD_DIVU) begin
          // A set shifted-out MSB means the partial remainder exceeds any
          // divisor, so the subtraction is taken even without a carry.
          if (hi_q[WIDTH-1] | carry) begin
            hi_d = alu_result;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = alu_a;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          // Multiplier bits are consumed from lo[0] while product bits shift
          // in from the top, carry included.
          if (lo_q[0]) begin
            {hi_d, lo_d} = {carry, alu_result, lo_q[WIDTH-1:1]};
          end else begin
            {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
          end
        end
        if (cnt_q == LAST_ITER) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= MD_MULTU;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule : mul_div_seq

// File: tb/tb_mul_div_seq.sv
// ----------------------------------------------------------------------------
// tb_mul_div_seq
//   Self-checking bench for mul_div_seq. Includes a behavioural model of the
//   external ALU and an arithmetic reference for MULTU/DIVU results.
// ----------------------------------------------------------------------------
module tb_mul_div_seq;
  import mul_div_seq_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [3:0]   alu_opcode;
  logic         alu_zero, alu_overflow;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_div_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .src_a        (src_a),
    .src_b        (src_b),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .busy         (busy),
    .done         (done),
    .div_by_zero  (div_by_zero),
    .hi           (hi),
    .lo           (lo)
  );

  // External 32-bit ALU, behavioural.
  always_comb begin
    case (alu_opcode)
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_NOR: alu_result = ~(alu_a | alu_b);
      default: alu_result = '0;
    endcase
  end
  assign alu_zero     = (alu_result == '0);
  assign alu_overflow = (alu_opcode == ALU_ADD)
                        ? (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1])
                        : (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic.
  task automatic ref_model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] eh, output logic [W-1:0] el,
                           output logic edz);
    logic [63:0] p;
    edz = 1'b0;
    if (o == MD_MULTU) begin
      p  = 64'(a) * 64'(b);
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 0) begin
      eh  = a;
      el  = '1;
      edz = 1'b1;
    end else begin
      eh = a % b;
      el = a / b;
    end
  endtask

  // Issue one operation and check result, latency, busy span and handshake.
  // poke_at >= 0 pulses start (with different operands) at that cycle of RUN.
  task automatic run_op(input string tag, input logic o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int poke_at);
    logic [W-1:0] eh, el;
    logic         edz;
    int           cyc, busy_n;
    ref_model(o, a, b, eh, el, edz);

    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = ~o; src_a = $urandom; src_b = $urandom;

    if (!edz) begin
      check({tag, " run opcode"}, 64'(alu_opcode), 64'(o ? ALU_SUB : ALU_ADD));
      check({tag, " run alu_b"},  64'(alu_b),      64'(o ? b : a));
    end

    cyc = 0; busy_n = 0;
    while (!done && cyc < 100) begin
      if (busy) busy_n++;
      if (cyc == poke_at) begin
        start = 1'b1; op = ~o; src_a = $urandom; src_b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;

    check({tag, " latency"},  64'(cyc),    64'(edz ? 0 : W));
    check({tag, " busy len"}, 64'(busy_n), 64'(edz ? 0 : W));
    check({tag, " hi"},       64'(hi),     64'(eh));
    check({tag, " lo"},       64'(lo),     64'(el));
    check({tag, " dbz"},      64'(div_by_zero), 64'(edz));
    check({tag, " busy@done"}, 64'(busy),  64'd0);

    @(posedge clk); #1;
    check({tag, " done pulse"}, 64'(done),      64'd0);
    check({tag, " hold hi/lo"}, {hi, lo},       {eh, el});
    check({tag, " idle alu"},   {28'd0, alu_opcode, alu_a}, {28'd0, ALU_ADD, 32'd0});
  endtask

  initial begin
    logic        saw_done;
    logic        ro;
    logic [W-1:0] ra, rb;

    // Reset state
    #12;
    check("reset hi/lo",  {hi, lo}, 64'd0);
    check("reset flags",  64'({busy, done, div_by_zero}), 64'd0);
    check("reset alu",    {alu_a, alu_b}, 64'd0);
    check("reset opcode", 64'(alu_opcode), 64'(ALU_ADD));
    @(negedge clk);
    reset = 1'b0;

    // Directed cases
    run_op("mul 7x6",        MD_MULTU, 32'd7,        32'd6,        -1);
    run_op("mul max x max",  MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
    run_op("div 100/7",      MD_DIVU,  32'd100,      32'd7,        -1);
    run_op("div max/1",      MD_DIVU,  32'hFFFFFFFF, 32'd1,        -1);
    run_op("div 8000/ffff",  MD_DIVU,  32'h80000000, 32'hFFFFFFFF, -1);
    run_op("div 5/0",        MD_DIVU,  32'd5,        32'd0,        -1);
    run_op("mul start@10",   MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 10);

    // Reset mid-RUN
    @(negedge clk);
    op = MD_MULTU; src_a = 32'hDEAD_BEEF; src_b = 32'h0000_FFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midrst hi/lo",  {hi, lo}, 64'd0);
    check("midrst flags",  64'({busy, done, div_by_zero}), 64'd0);
    check("midrst alu",    {alu_a, alu_b}, 64'd0);
    check("midrst opcode", 64'(alu_opcode), 64'(ALU_ADD));
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      saw_done |= done;
    end
    check("midrst no done", 64'(saw_done), 64'd0);
    run_op("after reset mul", MD_MULTU, 32'hDEAD_BEEF, 32'h0000_FFFF, -1);

    // Randomized operations, including occasional small / zero divisors
    for (int i = 0; i < 16; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op(ro ? "rand div" : "rand mul", ro, ra, rb, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mul_div_seq
